// File: rtl/ps2_mouse_master_ext_pkg.sv
// Shared types and PS/2 mouse protocol bytes for the mouse host controller.
// The init script is a flat list of send/expect steps, indexed by the FSM.
package ps2_mouse_master_ext_pkg;

  typedef enum logic [2:0] {
    S_SEND,
    S_TX_WAIT,
    S_RX,
    S_STREAM,
    S_FAULT
  } state_e;

  typedef enum logic [1:0] {
    ACT_TX,
    ACT_RX,
    ACT_ID,
    ACT_DONE
  } act_kind_e;

  typedef struct packed {
    act_kind_e  kind;
    logic [7:0] data;
  } init_act_t;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] CMD_GET_ID   = 8'hF2;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RATE_200     = 8'hC8;
  localparam logic [7:0] RATE_100     = 8'h64;
  localparam logic [7:0] RATE_80      = 8'h50;
  localparam logic [7:0] ID_STD       = 8'h00;
  localparam logic [7:0] ID_WHEEL     = 8'h03;

  // Wheel detection is the 200/100/80 sample-rate knock followed by Get ID.
  function automatic init_act_t init_action(input logic [4:0] idx, input logic wheel);
    init_act_t a;
    a = '{ACT_DONE, 8'h00};
    if (idx < 5'd4) begin
      case (idx)
        5'd0:    a = '{ACT_TX, CMD_RESET};
        5'd1:    a = '{ACT_RX, RSP_ACK};
        5'd2:    a = '{ACT_RX, RSP_BAT_OK};
        default: a = '{ACT_RX, ID_STD};
      endcase
    end else if (wheel) begin
      case (idx)
        5'd4:  a = '{ACT_TX, CMD_SET_RATE};
        5'd6:  a = '{ACT_TX, RATE_200};
        5'd8:  a = '{ACT_TX, CMD_SET_RATE};
        5'd10: a = '{ACT_TX, RATE_100};
        5'd12: a = '{ACT_TX, CMD_SET_RATE};
        5'd14: a = '{ACT_TX, RATE_80};
        5'd16: a = '{ACT_TX, CMD_GET_ID};
        5'd18: a = '{ACT_ID, 8'h00};
        5'd19: a = '{ACT_TX, CMD_ENABLE};
        5'd5, 5'd7, 5'd9, 5'd11, 5'd13, 5'd15, 5'd17, 5'd20:
               a = '{ACT_RX, RSP_ACK};
        default: a = '{ACT_DONE, 8'h00};
      endcase
    end else begin
      case (idx)
        5'd4:    a = '{ACT_TX, CMD_ENABLE};
        5'd5:    a = '{ACT_RX, RSP_ACK};
        default: a = '{ACT_DONE, 8'h00};
      endcase
    end
    return a;
  endfunction

endpackage

// File: rtl/ps2_mouse_master_ext_timeout.sv
// Down-counter watchdog: reloads on clear, counts while enabled,
// expired is the terminal-count compare.
module ps2_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 25_000_000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TC_LOAD = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RESET || clear) begin
      cnt <= TC_LOAD;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/ps2_mouse_master_ext.sv
// PS/2 mouse host: reset/identify/enable init sequence, then packet streaming.
// state     | meaning
// S_SEND    | one-cycle SEND_BYTE request for the current init command
// S_TX_WAIT | command held, waiting for BYTE_SENT
// S_RX      | waiting for the expected response byte (or device ID)
// S_STREAM  | init done, assembling 3/4-byte movement packets
// S_FAULT   | retries exhausted, idle until RESET
module ps2_mouse_master_ext
  import ps2_mouse_master_ext_pkg::*;
#(
  parameter int ENABLE_WHEEL   = 1,
  parameter int TIMEOUT_CYCLES = 25_000_000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
  output logic [7:0] MOUSE_DZ,
  output logic       SEND_INTERRUPT,
  output logic       WHEEL_MODE,
  output logic       INIT_DONE,
  output logic       INIT_FAIL
);

  localparam logic       WHEEL_EN    = (ENABLE_WHEEL != 0);
  localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRIES - 1);

  state_e     state, state_nxt;
  logic [4:0] act_idx, act_idx_nxt;
  logic [7:0] retry_cnt, retry_nxt;
  logic       wheel_q, wheel_nxt;
  logic       advance, fail;
  init_act_t  act_cur, act_next;
  logic       tmr_clear, tmr_enable, tmr_expired;
  logic [1:0] pkt_idx;
  logic [1:0] pkt_last;
  logic [7:0] buf0, buf1, buf2;

  assign act_cur  = init_action(act_idx, WHEEL_EN);
  assign act_next = init_action(act_idx + 5'd1, WHEEL_EN);
  assign pkt_last = wheel_q ? 2'd3 : 2'd2;

  assign tmr_enable = (state == S_TX_WAIT) || (state == S_RX) ||
                      ((state == S_STREAM) && (pkt_idx != 2'd0));

  ps2_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .CLK     (CLK),
    .RESET   (RESET),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .expired (tmr_expired)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_SEND;
      act_idx   <= '0;
      retry_cnt <= '0;
      wheel_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      act_idx   <= act_idx_nxt;
      retry_cnt <= retry_nxt;
      wheel_q   <= wheel_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    act_idx_nxt = act_idx;
    retry_nxt   = retry_cnt;
    wheel_nxt   = wheel_q;
    advance     = 1'b0;
    fail        = 1'b0;
    case (state)
      S_SEND: state_nxt = S_TX_WAIT;
      S_TX_WAIT: begin
        if (BYTE_SENT) advance = 1'b1;
        else if (tmr_expired) fail = 1'b1;
      end
      S_RX: begin
        if (BYTE_READY) begin
          if (BYTE_ERROR_CODE != 2'b00) begin
            fail = 1'b1;
          end else if (act_cur.kind == ACT_ID) begin
            if (BYTE_READ == ID_WHEEL) begin
              wheel_nxt = 1'b1;
              advance   = 1'b1;
            end else if (BYTE_READ == ID_STD) begin
              wheel_nxt = 1'b0;
              advance   = 1'b1;
            end else begin
              fail = 1'b1;
            end
          end else if (BYTE_READ == act_cur.data) begin
            advance = 1'b1;
          end else begin
            fail = 1'b1;
          end
        end else if (tmr_expired) begin
          fail = 1'b1;
        end
      end
      default: ;
    endcase
    if (advance) begin
      act_idx_nxt = act_idx + 5'd1;
      case (act_next.kind)
        ACT_TX:   state_nxt = S_SEND;
        ACT_DONE: state_nxt = S_STREAM;
        default:  state_nxt = S_RX;
      endcase
    end
    if (fail) begin
      wheel_nxt   = 1'b0;
      act_idx_nxt = '0;
      if (retry_cnt >= RETRY_LIMIT) begin
        state_nxt = S_FAULT;
      end else begin
        retry_nxt = retry_cnt + 8'd1;
        state_nxt = S_SEND;
      end
    end
    tmr_clear = (state_nxt != state) || advance || ((state == S_STREAM) && BYTE_READY);
  end

  // Packet assembly; the final byte is taken straight from BYTE_READ.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pkt_idx        <= '0;
      buf0           <= '0;
      buf1           <= '0;
      buf2           <= '0;
      MOUSE_STATUS   <= '0;
      MOUSE_DX       <= '0;
      MOUSE_DY       <= '0;
      MOUSE_DZ       <= '0;
      SEND_INTERRUPT <= 1'b0;
    end else begin
      SEND_INTERRUPT <= 1'b0;
      if (state == S_STREAM) begin
        if (BYTE_READY) begin
          if (BYTE_ERROR_CODE != 2'b00) begin
            pkt_idx <= '0;
          end else if ((pkt_idx == 2'd0) && !BYTE_READ[3]) begin
            pkt_idx <= '0;
          end else if (pkt_idx == pkt_last) begin
            MOUSE_STATUS   <= buf0;
            MOUSE_DX       <= buf1;
            MOUSE_DY       <= wheel_q ? buf2 : BYTE_READ;
            MOUSE_DZ       <= wheel_q ? BYTE_READ : 8'h00;
            SEND_INTERRUPT <= 1'b1;
            pkt_idx        <= '0;
          end else begin
            case (pkt_idx)
              2'd0:    buf0 <= BYTE_READ;
              2'd1:    buf1 <= BYTE_READ;
              default: buf2 <= BYTE_READ;
            endcase
            pkt_idx <= pkt_idx + 2'd1;
          end
        end else if ((pkt_idx != 2'd0) && tmr_expired) begin
          pkt_idx <= '0;
        end
      end
    end
  end

  assign SEND_BYTE    = (state == S_SEND) && !RESET;
  assign BYTE_TO_SEND = (((state == S_SEND) || (state == S_TX_WAIT)) && !RESET) ? act_cur.data : 8'h00;
  assign READ_ENABLE  = (state == S_RX) || (state == S_STREAM);
  assign INIT_DONE    = (state == S_STREAM);
  assign INIT_FAIL    = (state == S_FAULT);
  assign WHEEL_MODE   = wheel_q;

endmodule

// File: tb/tb_ps2_mouse_master_ext.sv
// Randomized bench for ps2_mouse_master_ext: scripted device for init,
// queue-based packet model for streaming.
module tb_ps2_mouse_master_ext;

  localparam int TMO = 100;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT = 1'b0;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ = 8'h00;
  logic [1:0] BYTE_ERROR_CODE = 2'b00;
  logic       BYTE_READY = 1'b0;
  logic [7:0] MOUSE_STATUS, MOUSE_DX, MOUSE_DY, MOUSE_DZ;
  logic       SEND_INTERRUPT, WHEEL_MODE, INIT_DONE, INIT_FAIL;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [7:0]  tx_log[$];
  logic [7:0]  part_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] last_pkt = '0;
  bit          mdl_wheel = 1'b0;

  ps2_mouse_master_ext #(.ENABLE_WHEEL(1), .TIMEOUT_CYCLES(TMO), .MAX_RETRIES(3)) dut (
    .CLK(CLK), .RESET(RESET), .SEND_BYTE(SEND_BYTE), .BYTE_TO_SEND(BYTE_TO_SEND),
    .BYTE_SENT(BYTE_SENT), .READ_ENABLE(READ_ENABLE), .BYTE_READ(BYTE_READ),
    .BYTE_ERROR_CODE(BYTE_ERROR_CODE), .BYTE_READY(BYTE_READY),
    .MOUSE_STATUS(MOUSE_STATUS), .MOUSE_DX(MOUSE_DX), .MOUSE_DY(MOUSE_DY), .MOUSE_DZ(MOUSE_DZ),
    .SEND_INTERRUPT(SEND_INTERRUPT), .WHEEL_MODE(WHEEL_MODE), .INIT_DONE(INIT_DONE),
    .INIT_FAIL(INIT_FAIL)
  );

  initial forever #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] mouse_out();
    return {MOUSE_STATUS, MOUSE_DX, MOUSE_DY, MOUSE_DZ};
  endfunction

  // Host-side transmitter: logs each request and acknowledges after a few cycles.
  initial forever begin
    @(negedge CLK);
    if (SEND_BYTE === 1'b1) begin
      tx_log.push_back(BYTE_TO_SEND);
      repeat (3) @(negedge CLK);
      BYTE_SENT = 1'b1;
      @(negedge CLK);
      BYTE_SENT = 1'b0;
    end
  end

  initial forever begin
    @(negedge CLK);
    if (SEND_INTERRUPT === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("irq_unexpected", 64'(SEND_INTERRUPT), 64'(0));
      end else begin
        last_pkt = exp_q.pop_front();
        check("packet", 64'(mouse_out()), 64'(last_pkt));
      end
    end
  end

  // Packet model: a packet starts with a bit3=1 byte; errors drop the partial.
  task automatic mdl_byte(input logic [7:0] b, input logic [1:0] e);
    logic [7:0] dz;
    if (e != 2'b00) begin
      part_q.delete();
    end else if (part_q.size() == 0 && b[3] == 1'b0) begin
    end else begin
      part_q.push_back(b);
      if (part_q.size() == (mdl_wheel ? 4 : 3)) begin
        dz = mdl_wheel ? b : 8'h00;
        exp_q.push_back({part_q[0], part_q[1], part_q[2], dz});
        part_q.delete();
      end
    end
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic [1:0] e);
    BYTE_READ = b;
    BYTE_ERROR_CODE = e;
    BYTE_READY = 1'b1;
    @(negedge CLK);
    BYTE_READY = 1'b0;
    BYTE_ERROR_CODE = 2'b00;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic [1:0] e);
    mdl_byte(b, e);
    drive_rx(b, e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
    if (n > TMO) part_q.delete();
  endtask

  task automatic expect_cmd(input logic [7:0] exp);
    int waited = 0;
    while (tx_log.size() == 0 && waited < 500) begin
      @(negedge CLK);
      waited++;
    end
    if (tx_log.size() == 0) check("cmd_wait", 64'(tx_log.size()), 64'(1));
    else check("cmd", 64'(tx_log.pop_front()), 64'(exp));
  endtask

  task automatic respond(input logic [7:0] b);
    int waited = 0;
    while (READ_ENABLE !== 1'b1 && waited < 500) begin
      @(negedge CLK);
      waited++;
    end
    check("rd_en_wait", 64'(READ_ENABLE), 64'(1));
    if (READ_ENABLE === 1'b1) drive_rx(b, 2'b00);
  endtask

  // Device side of init; an ID other than 00/03 ends the script early.
  task automatic do_init(input logic [7:0] id);
    logic [7:0] cmds [9];
    cmds = '{8'hFF, 8'hF3, 8'hC8, 8'hF3, 8'h64, 8'hF3, 8'h50, 8'hF2, 8'hF4};
    for (int i = 0; i < 9; i++) begin
      expect_cmd(cmds[i]);
      respond(8'hFA);
      if (cmds[i] == 8'hFF) begin
        respond(8'hAA);
        respond(8'h00);
      end else if (cmds[i] == 8'hF2) begin
        respond(id);
        if (id != 8'h00 && id != 8'h03) return;
      end
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    @(negedge CLK);
    check("reset_zero", {18'd0, mouse_out(), SEND_INTERRUPT, SEND_BYTE, BYTE_TO_SEND,
                         READ_ENABLE, WHEEL_MODE, INIT_DONE, INIT_FAIL}, 64'(0));
    repeat (6) @(negedge CLK);
    tx_log.delete();
    part_q.delete();
    last_pkt = '0;
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check("release_send", {55'd0, SEND_BYTE, BYTE_TO_SEND}, {55'd0, 1'b1, 8'hFF});
  endtask

  task automatic rand_stream(input int n);
    for (int i = 0; i < n; i++) begin
      int k;
      logic [7:0] b;
      k = int'($urandom_range(0, 9));
      b = 8'($urandom);
      if (k == 0) b[3] = 1'b0;
      if (k >= 6) b[3] = 1'b1;
      send_rx(b, (k == 1) ? 2'($urandom_range(1, 3)) : 2'b00);
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end
  endtask

  task automatic end_phase(input string tag);
    idle(150);
    check({tag, "_pending"}, 64'(exp_q.size()), 64'(0));
    check({tag, "_hold"}, 64'(mouse_out()), 64'(last_pkt));
  endtask

  initial begin
    int waited;
    int nff;

    // 3-byte mode: device reports standard ID
    do_reset();
    do_init(8'h00);
    check("init_done_std", {62'd0, INIT_DONE, WHEEL_MODE}, {62'd0, 2'b10});
    mdl_wheel = 1'b0;
    send_rx(8'h00, 2'b00); send_rx(8'h08, 2'b00); send_rx(8'h10, 2'b00); send_rx(8'h20, 2'b00);
    idle(3);
    check("resync", 64'(mouse_out()), 64'(32'h08102000));
    send_rx(8'h08, 2'b00); send_rx(8'h10, 2'b01);
    send_rx(8'h09, 2'b00); send_rx(8'h01, 2'b00); send_rx(8'h02, 2'b00);
    idle(3);
    check("err_mid", 64'(mouse_out()), 64'(32'h09010200));
    rand_stream(60);
    idle(150);
    send_rx(8'h0C, 2'b00);
    idle(150);
    send_rx(8'h18, 2'b00); send_rx(8'h33, 2'b00); send_rx(8'h44, 2'b00);
    end_phase("std");

    // wheel mode
    do_reset();
    do_init(8'h03);
    check("init_done_wheel", {62'd0, INIT_DONE, WHEEL_MODE}, {62'd0, 2'b11});
    mdl_wheel = 1'b1;
    send_rx(8'h08, 2'b00); send_rx(8'h05, 2'b00); send_rx(8'hFB, 2'b00); send_rx(8'h01, 2'b00);
    idle(3);
    check("wheel_pkt", 64'(mouse_out()), 64'(32'h0805FB01));
    rand_stream(80);
    end_phase("wheel");
    send_rx(8'h08, 2'b00); send_rx(8'h11, 2'b00);
    do_reset();
    check("mid_reset_pending", 64'(exp_q.size()), 64'(0));

    // unrecognised ID fails the attempt and restarts at FF
    do_reset();
    do_init(8'h05);
    expect_cmd(8'hFF);
    check("bad_id_not_done", 64'(INIT_DONE), 64'(0));

    // silent device
    do_reset();
    waited = 0;
    while (INIT_FAIL !== 1'b1 && waited < 2000) begin
      @(negedge CLK);
      waited++;
    end
    check("fault_reached", 64'(INIT_FAIL), 64'(1));
    nff = tx_log.size();
    check("ff_sends", 64'(nff), 64'(3));
    idle(300);
    check("fault_no_send", 64'(tx_log.size()), 64'(nff));
    check("fault_outputs", {61'd0, INIT_FAIL, READ_ENABLE, INIT_DONE}, {61'd0, 3'b100});
    while (tx_log.size() > 0) check("ff_byte", 64'(tx_log.pop_front()), 64'(8'hFF));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
